// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the program-sequencing front end.
//   - Width parameters used by fetch_ctl and by decode.
//   - fetch_state_t: front-end FSM states.
//   - START_ADDR: program entry points selected by prog_sel.
//   - BR_LUT: absolute branch targets, regenerated by the assembler flow.
package fetch_pkg;

  localparam int PC_W      = 10;
  localparam int OFS_W     = 8;
  localparam int LUT_IDX_W = 4;
  localparam int CT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Entry points: multiply, pattern search, min-distance, spare.
  localparam logic [PC_W-1:0] START_ADDR [4] = '{
    10'd0, 10'd64, 10'd128, 10'd192
  };

  // Absolute branch target table (assembler-generated contents).
  localparam logic [PC_W-1:0] BR_LUT [16] = '{
    10'd0,   10'd16,  10'd200, 10'd300,
    10'd400, 10'd500, 10'd600, 10'd700,
    10'd32,  10'd96,  10'd160, 10'd224,
    10'd512, 10'd768, 10'd1000, 10'd1023
  };

  function automatic logic [PC_W-1:0] start_addr(input logic [1:0] sel);
    return START_ADDR[sel];
  endfunction

endpackage

// File: rtl/fetch_ctl_branch_lut.sv
// branch_lut: combinational 16-entry table of absolute branch targets.
//   br_idx  in  LUT_IDX_W  table index from the branch instruction
//   target  out PC_W       absolute target address
module branch_lut
  import fetch_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] br_idx,
  output logic [PC_W-1:0]      target
);

  assign target = BR_LUT[br_idx];

endmodule

// File: rtl/fetch_ctl.sv
// fetch_ctl: owns the program counter, drives the instruction-ROM address,
// applies branches and reports completion.
//   clk        in   system clock, rising edge
//   init_n     in   asynchronous active-low reset
//   go         in   start pulse, honoured in IDLE or HALT
//   prog_sel   in   entry-point select, sampled with go
//   halt       in   decode saw the halt instruction
//   stall      in   hold PC this cycle (overrides branches)
//   br_en      in   branch instruction in decode
//   br_taken   in   branch condition true
//   br_abs     in   1: target from LUT[br_idx], 0: PC + br_ofs
//   br_idx     in   LUT index
//   br_ofs     in   signed relative offset
//   imem_addr  out  current PC (registered)
//   instr_vld  out  high in RUN (registered state decode)
//   done       out  high in HALT (registered state decode)
//   cycle_ct   out  saturating count of RUN cycles since last start
//   pc_wrap    out  sticky: sequential increment wrapped past all-ones
module fetch_ctl
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 init_n,
  input  logic                 go,
  input  logic [1:0]           prog_sel,
  input  logic                 halt,
  input  logic                 stall,
  input  logic                 br_en,
  input  logic                 br_taken,
  input  logic                 br_abs,
  input  logic [LUT_IDX_W-1:0] br_idx,
  input  logic [OFS_W-1:0]     br_ofs,
  output logic [PC_W-1:0]      imem_addr,
  output logic                 instr_vld,
  output logic                 done,
  output logic [CT_W-1:0]      cycle_ct,
  output logic                 pc_wrap
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CT_W-1:0] ct_q, ct_d;
  logic            wrap_q, wrap_d;

  logic [PC_W-1:0] lut_target;
  logic [PC_W-1:0] ofs_ext;

  branch_lut u_branch_lut (
    .br_idx (br_idx),
    .target (lut_target)
  );

  assign ofs_ext = {{(PC_W-OFS_W){br_ofs[OFS_W-1]}}, br_ofs};

  // State register plus datapath registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ct_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ct_q    <= ct_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: if (go)   state_d = RUN;
      RUN:        if (halt) state_d = HALT;
      default:              state_d = IDLE;
    endcase
  end

  // PC, cycle counter and wrap flag next values.
  always_comb begin
    pc_d   = pc_q;
    ct_d   = ct_q;
    wrap_d = wrap_q;
    case (state_q)
      IDLE, HALT: begin
        if (go) begin
          pc_d   = start_addr(prog_sel);
          ct_d   = '0;
          wrap_d = 1'b0;
        end
      end
      RUN: begin
        // Counts every RUN cycle, including stall and halt cycles.
        if (ct_q != '1) ct_d = ct_q + CT_W'(1);
        if (halt || stall) begin
          pc_d = pc_q;
        end else if (br_en && br_taken) begin
          // Relative target wraps modulo 2^PC_W without touching pc_wrap.
          pc_d = br_abs ? lut_target : pc_q + ofs_ext;
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (pc_q == '1) wrap_d = 1'b1;
        end
      end
      default: begin
        pc_d = '0;
      end
    endcase
  end

  // Outputs: pure decodes of registered state, no input-to-output path.
  always_comb begin
    imem_addr = pc_q;
    instr_vld = (state_q == RUN);
    done      = (state_q == HALT);
    cycle_ct  = ct_q;
    pc_wrap   = wrap_q;
  end

endmodule

// File: doc/fetch_ctl.md
# fetch_ctl

Program-sequencing front end of the CSE141L core: owns the program counter, drives the instruction-memory address, applies branches, and generates `done`. It sits directly upstream of decode/execute inside `top`. The bench starts each program (multiply, pattern search, min-distance) by pulsing `go` with a program select and waits on `done`. It also exports a run-cycle count for the bench.

## Interface
- `PC_W`, 10: program counter / instruction address width.
- `OFS_W`, 8: signed relative branch offset width.
- `LUT_IDX_W`, 4: branch lookup-table index width (16 absolute targets).
- `CT_W`, 16: cycle counter width.

- `clk`  in  1  system clock, rising edge.
- `init_n`  in  1  asynchronous, active-low reset.
- `go`  in  1  start pulse, sampled in IDLE or HALT.
- `prog_sel`  in  2  start-address select, sampled with `go`.
- `halt`  in  1  decode saw the halt instruction.
- `stall`  in  1  hold PC this cycle.
- `br_en`  in  1  branch instruction in decode.
- `br_taken`  in  1  branch condition true.
- `br_abs`  in  1  1 = target from LUT[`br_idx`]; 0 = PC + `br_ofs`.
- `br_idx`  in  LUT_IDX_W  LUT index.
- `br_ofs`  in  OFS_W  signed offset.
- `imem_addr`  out  PC_W  current PC, fed to instruction ROM.
- `instr_vld`  out  1  high while in RUN; decode may act on ROM output.
- `done`  out  1  high in HALT.
- `cycle_ct`  out  CT_W  RUN cycles since last start.
- `pc_wrap`  out  1  sticky: PC wrapped past all-ones this run.

## Operation
- States: IDLE, RUN, HALT.
- IDLE:
  - `go` → RUN.
  - PC ← START[`prog_sel`].
  - `cycle_ct` ← 0, `pc_wrap` ← 0.
- RUN, next-PC priority (highest first):
  - `halt` → HALT, PC holds.
  - `stall` → PC holds; any branch is ignored.
  - `br_en & br_taken & br_abs` → PC ← LUT[`br_idx`].
  - `br_en & br_taken & !br_abs` → PC ← PC + sign-extended `br_ofs`, modulo 2^PC_W.
  - Otherwise PC ← PC + 1.
- Wrap-around:
  - Increment from all-ones yields 0 and sets `pc_wrap`.
  - Relative branches that wrap do not set `pc_wrap`.
- `go` in RUN is ignored.
- HALT:
  - `done`=1, PC holds.
  - `go` restarts exactly as from IDLE.
- `cycle_ct`:
  - Increments every RUN cycle, including stall and halt cycles.
  - Saturates at all-ones.
  - Holds in HALT.
- Reset values (`init_n` low, asynchronous):
  - State IDLE.
  - PC=0, so `imem_addr`=0.
  - `instr_vld`=0, `done`=0, `cycle_ct`=0, `pc_wrap`=0.
- Reset mid-run aborts immediately; no done pulse is produced.

## Timing
- `imem_addr` and `instr_vld` are registered state outputs; no combinational path from any input.
- `go` at edge n → RUN and PC=START at n+1; first instruction is valid the same cycle (combinational ROM).
- Taken branch sampled at edge n → target on `imem_addr` after edge n.
- Branch penalty is zero cycles (decode is combinational on ROM output).
- `halt` at edge n → `done`=1 after edge n and stays high until the `go` edge.
- `init_n` deassertion is synchronous to operation: the first `go` is honoured on the first rising edge with `init_n` high.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` {IDLE, RUN, HALT}.
  - `START` table constant: 0, 64, 128, 192 for `prog_sel` 0..3.
  - Width parameters shared with decode.
- Sub-module `branch_lut`:
  - Combinational 16-entry ROM indexed by `br_idx`.
  - Contents are a package constant written by the assembler flow.
- `fetch_ctl` holds the FSM, PC register, adder/mux, and counters.

## Test plan
- Reset: hold `init_n` low 3 cycles, release with `go`=0 → `imem_addr`=0, `instr_vld`=0, `done`=0 indefinitely.
- Start/sequence: `go`,`prog_sel`=1 → `imem_addr` 64, 65, 66…; `halt` on PC 70 → `done`=1 next cycle, `cycle_ct`=7, PC stays 70.
- Branches:
  - Relative `br_ofs`=−3 taken at PC 80 → 77.
  - Same branch with `br_taken`=0 → 81.
  - Absolute `br_idx`=2 with LUT[2]=200 → 200.
  - `stall` with a taken branch → PC unchanged.
- Wrap: `prog_sel`=3, force PC to 1023 via LUT, increment → PC 0, `pc_wrap`=1; next `go` clears it.
- Restart/ignore: `go` during RUN → no effect; `go`,`prog_sel`=2 in HALT → `done`=0, PC=128, `cycle_ct`=0 next cycle.
- Async reset mid-run: drop `init_n` between edges → outputs reach reset values before the next edge; no `done`.
